issue_queue_mw: RTL
===================

// Module: issue_queue_mw
// PURPOSE
//  Parametrised, multi-issue, age-ordered reservation station between rename and the FUs.
//  Per cycle it does three things:
//   - accepts one renamed instruction;
//   - wakes operands from NUM_CDB_P result buses;
//   - issues up to ISSUE_W_P oldest ready entries, at most one per FU, honouring FU back-pressure.
//  Adds over the single-issue table: N-wide issue, fu_ready_i stall, same-cycle CDB bypass on
//  enqueue, store-buffer id broadcast wakeup, and flush.
// PARAMETERS
//  ENTRIES_P    8   queue depth (>=2)
//  ISSUE_W_P    2   max instructions issued per cycle (1..NUM_FU_P)
//  NUM_FU_P     4   functional units (= NUM_FU)
//  NUM_CDB_P    4   result buses snooped
//  TAG_W_P      5   physical register tag width ($clog2(NUM_PHYS_REG))
//  DATA_W_P     16  operand width (WORD_SIZE_P)
//  SB_W_P       3   store-buffer id width ($clog2(SB_ENTRY))
//  PAYLOAD_W_P  48  opaque pass-through (pc, opcode, flags, rob_dest, imm...)
// PORTS
//  clk_i            in   1                    clock
//  reset_i          in   1                    asynchronous, active-high reset
//  flush_i          in   1                    squash all entries (mispredict)
//  enq_v_i          in   1                    enqueue request
//  enq_ready_o      out  1                    queue can accept this cycle
//  enq_src1_tag_i   in   TAG_W_P              src1 phys tag
//  enq_src1_rdy_i   in   1                    src1 data valid from RF
//  enq_src1_data_i  in   DATA_W_P             src1 RF data
//  enq_src2_tag_i   in   TAG_W_P              src2 phys tag
//  enq_src2_rdy_i   in   1                    src2 valid (RF hit or immediate)
//  enq_src2_data_i  in   DATA_W_P             src2 data / immediate
//  enq_fu_i         in   $clog2(NUM_FU_P)     target FU
//  enq_wait_sb_i    in   1                    entry must wait for store-buffer clear
//  enq_sb_id_i      in   SB_W_P               store-buffer id waited on
//  enq_payload_i    in   PAYLOAD_W_P          pass-through fields
//  cdb_v_i          in   NUM_CDB_P            per-bus valid
//  cdb_tag_i        in   NUM_CDB_P*TAG_W_P    per-bus dest tag
//  cdb_data_i       in   NUM_CDB_P*DATA_W_P   per-bus result
//  sb_clr_v_i       in   1                    store-buffer clear broadcast valid
//  sb_clr_id_i      in   SB_W_P               store-buffer id cleared
//  fu_ready_i       in   NUM_FU_P             FU can take an op next cycle
//  iss_v_o          out  ISSUE_W_P            issue slot valid
//  iss_fu_o         out  ISSUE_W_P*$clog2(NUM_FU_P)   slot target FU
//  iss_src1_o       out  ISSUE_W_P*DATA_W_P   slot operand 1
//  iss_src2_o       out  ISSUE_W_P*DATA_W_P   slot operand 2
//  iss_payload_o    out  ISSUE_W_P*PAYLOAD_W_P   slot payload
//  count_o          out  $clog2(ENTRIES_P+1)  occupied entries
// BEHAVIOUR
//  - Reset (async): all valids, age matrix, count_o, iss_* and enq_ready_o = 0. enq_ready_o = 1 the
//    first clock after reset deasserts.
//  - Enqueue: accepted iff enq_v_i & enq_ready_o & ~flush_i. Written to the lowest free slot; it
//    becomes younger than every valid entry.
//  - enq_ready_o is registered: next = (count_n < ENTRIES_P).
//  - Bypass: an enqueue srcN with rdy=0 whose tag matches a valid CDB bus that cycle is stored
//    ready with the CDB data.
//  - Wakeup: valid entry, srcN not ready, tag == cdb_tag[b] & cdb_v[b] -> data captured, ready set
//    next edge. Multiple bus hits: lowest b wins.
//  - Store-buffer wakeup: sb_clr_v_i & sb_id == sb_clr_id_i clears the entry's wait bit.
//  - Ready = valid & src1_rdy & src2_rdy & ~wait_sb, judged on registered state only. An entry
//    woken or enqueued this cycle is eligible next cycle.
//  - Select: slot k takes the oldest ready entry not taken by slots <k, with fu_ready_i[fu]=1 and
//    FU not already used by slots <k. Slot 0 is always the oldest selected.
//  - Issued entries are invalidated at the edge.
//  - Issue outputs are registered: 1-cycle latency select->iss_*. Unused slots drive v=0 and data=0.
//  - count_n = count + enq_acc - popcount(selected). Full with simultaneous issue: enq_ready_o was
//    already 0 and is not bypassed.
//  - Flush: next edge all valids = 0, count = 0, iss_v_o = 0. This includes selections made in the
//    flush cycle, and flush overrides enqueue.
// STRUCTURE
//  - issue_queue_mw: storage arrays, wakeup compare, count, output registers.
//  - Sub-module issue_age_select: ENTRIES_P x ENTRIES_P age matrix (row i = i older than j), set
//    row/col on enqueue; ISSUE_W_P-stage oldest-ready pick with FU masking; outputs one-hot grants.
//  - Purple_Jade_pkg gains the iq_entry_t struct (tags, data, rdy bits, fu, sb fields, payload) and
//    the ISSUE_W constant.
// TESTING
//  - Enqueue 3 ALU ops with all sources ready, fu_ready=1111 -> oldest issues on slot 0 the next
//    cycle. With two ALU ops and one on FU2, the cycle after select gives v=11: slot0 oldest ALU,
//    slot1 the FU2 op.
//  - Enqueue src1 tag 7 not ready while cdb0 v=1 tag=7 data=0xBEEF -> entry issues the following
//    cycle with src1=0xBEEF (bypass).
//  - Fill all 8 entries, no FU ready -> enq_ready_o=0, count_o=8. Raise fu_ready -> issue 2, and
//    enq_ready_o returns the following cycle.
//  - Entry with wait_sb=1, sb_id=3: clear id 2 -> no issue. Clear id 3 -> issue 2 cycles later.
//  - Flush while 5 entries are valid and a selection is pending -> iss_v_o=0 and count_o=0 next
//    cycle, and the concurrent enqueue is dropped.
//  - Assert reset_i mid-issue, off-edge -> iss_v_o and enq_ready_o drop immediately, all entries
//    gone after release.

Source files
------------

// File: rtl/issue_queue_mw_pkg.sv
// rtl/issue_queue_mw_pkg.sv - shared sizes and entry record for the multi-issue reservation station
// Purpose: default geometry constants and the per-entry storage record.
// Ports: none (package).
package issue_queue_mw_pkg;

   localparam int ENTRIES   = 8;
   localparam int ISSUE_W   = 2;
   localparam int NUM_FU    = 4;
   localparam int NUM_CDB   = 4;
   localparam int TAG_W     = 5;
   localparam int DATA_W    = 16;
   localparam int SB_W      = 3;
   localparam int PAYLOAD_W = 48;
   localparam int FU_W      = $clog2(NUM_FU);

   // One reservation-station slot; the valid bit lives outside so it can be reset cheaply.
   typedef struct packed {
      logic [TAG_W-1:0]     src1_tag;
      logic                 src1_rdy;
      logic [DATA_W-1:0]    src1_data;
      logic [TAG_W-1:0]     src2_tag;
      logic                 src2_rdy;
      logic [DATA_W-1:0]    src2_data;
      logic [FU_W-1:0]      fu;
      logic                 wait_sb;
      logic [SB_W-1:0]      sb_id;
      logic [PAYLOAD_W-1:0] payload;
   } iq_entry_t;

endpackage

// File: rtl/issue_queue_mw_if.sv
// rtl/issue_queue_mw_if.sv - enqueue, wakeup, FU back-pressure and issue bundle
// Purpose: groups every non-clock/reset signal of issue_queue_mw.
// Ports: master = rename/CDB/FU side (drives *_i), slave = the queue (drives *_o).
interface issue_queue_mw_if
   import issue_queue_mw_pkg::*;
#(
   parameter int ENTRIES_P   = ENTRIES,
   parameter int ISSUE_W_P   = ISSUE_W,
   parameter int NUM_FU_P    = NUM_FU,
   parameter int NUM_CDB_P   = NUM_CDB,
   parameter int TAG_W_P     = TAG_W,
   parameter int DATA_W_P    = DATA_W,
   parameter int SB_W_P      = SB_W,
   parameter int PAYLOAD_W_P = PAYLOAD_W
) ();
   localparam int FU_W_L  = $clog2(NUM_FU_P);
   localparam int CNT_W_L = $clog2(ENTRIES_P + 1);

   logic                             flush_i;
   logic                             enq_v_i;
   logic                             enq_ready_o;
   logic [TAG_W_P-1:0]               enq_src1_tag_i;
   logic                             enq_src1_rdy_i;
   logic [DATA_W_P-1:0]              enq_src1_data_i;
   logic [TAG_W_P-1:0]               enq_src2_tag_i;
   logic                             enq_src2_rdy_i;
   logic [DATA_W_P-1:0]              enq_src2_data_i;
   logic [FU_W_L-1:0]                enq_fu_i;
   logic                             enq_wait_sb_i;
   logic [SB_W_P-1:0]                enq_sb_id_i;
   logic [PAYLOAD_W_P-1:0]           enq_payload_i;
   logic [NUM_CDB_P-1:0]             cdb_v_i;
   logic [NUM_CDB_P*TAG_W_P-1:0]     cdb_tag_i;
   logic [NUM_CDB_P*DATA_W_P-1:0]    cdb_data_i;
   logic                             sb_clr_v_i;
   logic [SB_W_P-1:0]                sb_clr_id_i;
   logic [NUM_FU_P-1:0]              fu_ready_i;
   logic [ISSUE_W_P-1:0]             iss_v_o;
   logic [ISSUE_W_P*FU_W_L-1:0]      iss_fu_o;
   logic [ISSUE_W_P*DATA_W_P-1:0]    iss_src1_o;
   logic [ISSUE_W_P*DATA_W_P-1:0]    iss_src2_o;
   logic [ISSUE_W_P*PAYLOAD_W_P-1:0] iss_payload_o;
   logic [CNT_W_L-1:0]               count_o;

   modport master (
      output flush_i, enq_v_i, enq_src1_tag_i, enq_src1_rdy_i, enq_src1_data_i,
             enq_src2_tag_i, enq_src2_rdy_i, enq_src2_data_i, enq_fu_i, enq_wait_sb_i,
             enq_sb_id_i, enq_payload_i, cdb_v_i, cdb_tag_i, cdb_data_i,
             sb_clr_v_i, sb_clr_id_i, fu_ready_i,
      input  enq_ready_o, iss_v_o, iss_fu_o, iss_src1_o, iss_src2_o, iss_payload_o, count_o
   );

   modport slave (
      input  flush_i, enq_v_i, enq_src1_tag_i, enq_src1_rdy_i, enq_src1_data_i,
             enq_src2_tag_i, enq_src2_rdy_i, enq_src2_data_i, enq_fu_i, enq_wait_sb_i,
             enq_sb_id_i, enq_payload_i, cdb_v_i, cdb_tag_i, cdb_data_i,
             sb_clr_v_i, sb_clr_id_i, fu_ready_i,
      output enq_ready_o, iss_v_o, iss_fu_o, iss_src1_o, iss_src2_o, iss_payload_o, count_o
   );

endinterface

// File: rtl/issue_queue_mw_age_select.sv
// rtl/issue_queue_mw_age_select.sv - age matrix and multi-slot oldest-ready picker
// Purpose: tracks relative age of all slots and grants up to ISSUE_W_P entries per cycle.
// Ports: clk_i/reset_i; flush_i clears ages; enq_i/enq_oh_i mark the newly written slot;
//        ready_i/entry_fu_i describe candidates; fu_ready_i masks FUs; grant_o one-hot per slot.
module issue_age_select #(
   parameter int ENTRIES_P = 8,
   parameter int ISSUE_W_P = 2,
   parameter int NUM_FU_P  = 4,
   parameter int FU_W_L    = $clog2(NUM_FU_P)
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 flush_i,
   input  logic                                 enq_i,
   input  logic [ENTRIES_P-1:0]                 enq_oh_i,
   input  logic [ENTRIES_P-1:0]                 ready_i,
   input  logic [ENTRIES_P-1:0][FU_W_L-1:0]     entry_fu_i,
   input  logic [NUM_FU_P-1:0]                  fu_ready_i,
   output logic [ISSUE_W_P-1:0][ENTRIES_P-1:0]  grant_o
);

   // older_q[i][j] = 1 means entry i is older than entry j.
   logic [ENTRIES_P-1:0] older_q [ENTRIES_P];
   logic [ENTRIES_P-1:0] older_d [ENTRIES_P];
   logic [ENTRIES_P-1:0] taken;
   logic [ENTRIES_P-1:0] cand;
   logic [NUM_FU_P-1:0]  fu_used;
   logic                 blocked;

   // A new entry is younger than everyone: clear its row, set its column.
   // Stale bits against empty slots are harmless; they are rewritten when those slots fill.
   always_comb begin
      for (int i = 0; i < ENTRIES_P; i++) begin
         older_d[i] = older_q[i];
         for (int j = 0; j < ENTRIES_P; j++) begin
            if (enq_i && enq_oh_i[i]) begin
               older_d[i][j] = 1'b0;
            end else if (enq_i && enq_oh_i[j]) begin
               older_d[i][j] = 1'b1;
            end
         end
         if (flush_i) begin
            older_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < ENTRIES_P; i++) begin
            older_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES_P; i++) begin
            older_q[i] <= older_d[i];
         end
      end
   end

   // Each slot removes earlier winners and their FUs, then takes the candidate nobody
   // else in the candidate set is older than.
   always_comb begin
      grant_o = '0;
      taken   = '0;
      fu_used = '0;
      cand    = '0;
      blocked = 1'b0;
      for (int k = 0; k < ISSUE_W_P; k++) begin
         for (int i = 0; i < ENTRIES_P; i++) begin
            cand[i] = ready_i[i] & ~taken[i] & fu_ready_i[entry_fu_i[i]] & ~fu_used[entry_fu_i[i]];
         end
         for (int i = 0; i < ENTRIES_P; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES_P; j++) begin
               if (cand[j] && older_q[j][i]) begin
                  blocked = 1'b1;
               end
            end
            if (cand[i] && !blocked) begin
               grant_o[k][i] = 1'b1;
            end
         end
         taken = taken | grant_o[k];
         for (int i = 0; i < ENTRIES_P; i++) begin
            if (grant_o[k][i]) begin
               fu_used[entry_fu_i[i]] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/issue_queue_mw.sv
// rtl/issue_queue_mw.sv - multi-issue age-ordered reservation station
// Purpose: holds renamed instructions, wakes operands from CDBs and store-buffer clears,
//          and issues up to ISSUE_W_P oldest ready entries per cycle with FU back-pressure.
// Ports: clk_i, reset_i (async, active-high); iq = slave side of issue_queue_mw_if
//        (enqueue, CDB snoop, store-buffer clear, fu_ready, registered issue slots, count).
module issue_queue_mw
   import issue_queue_mw_pkg::*;
#(
   parameter int ENTRIES_P   = ENTRIES,
   parameter int ISSUE_W_P   = ISSUE_W,
   parameter int NUM_FU_P    = NUM_FU,
   parameter int NUM_CDB_P   = NUM_CDB,
   parameter int TAG_W_P     = TAG_W,
   parameter int DATA_W_P    = DATA_W,
   parameter int SB_W_P      = SB_W,
   parameter int PAYLOAD_W_P = PAYLOAD_W
) (
   input  logic               clk_i,
   input  logic               reset_i,
   issue_queue_mw_if.slave    iq
);
   localparam int FU_W_L = $clog2(NUM_FU_P);
   localparam int CNT_W  = $clog2(ENTRIES_P + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES_P);

   iq_entry_t                               ent_q [ENTRIES_P];
   iq_entry_t                               ent_d [ENTRIES_P];
   iq_entry_t                               enq_ent;
   logic [ENTRIES_P-1:0]                    valid_q, valid_d;
   logic [ENTRIES_P-1:0]                    ready, free_oh, sel;
   logic [ENTRIES_P-1:0][FU_W_L-1:0]        ent_fu;
   logic [ISSUE_W_P-1:0][ENTRIES_P-1:0]     grant;
   logic                                    enq_acc;
   logic [CNT_W-1:0]                        count_q, count_d, sel_cnt;
   logic                                    enq_ready_q, enq_ready_d;
   logic [ISSUE_W_P-1:0]                    iss_v_q, iss_v_d;
   logic [ISSUE_W_P-1:0][FU_W_L-1:0]        iss_fu_q, iss_fu_d;
   logic [ISSUE_W_P-1:0][DATA_W_P-1:0]      iss_src1_q, iss_src1_d;
   logic [ISSUE_W_P-1:0][DATA_W_P-1:0]      iss_src2_q, iss_src2_d;
   logic [ISSUE_W_P-1:0][PAYLOAD_W_P-1:0]   iss_pl_q, iss_pl_d;

   // Flush overrides enqueue; enq_ready is the registered full flag, never bypassed by issue.
   assign enq_acc = iq.enq_v_i & enq_ready_q & ~iq.flush_i;

   // Lowest free slot: scanning downwards lets the lowest index overwrite.
   always_comb begin
      free_oh = '0;
      for (int i = ENTRIES_P - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_oh    = '0;
            free_oh[i] = 1'b1;
         end
      end
   end

   // Readiness uses registered state only, so wakeups take effect one cycle later.
   always_comb begin
      ready  = '0;
      ent_fu = '0;
      for (int i = 0; i < ENTRIES_P; i++) begin
         ready[i]  = valid_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy & ~ent_q[i].wait_sb;
         ent_fu[i] = ent_q[i].fu;
      end
   end

   // Incoming entry with same-cycle CDB bypass; descending scan makes the lowest bus win.
   always_comb begin
      enq_ent.src1_tag  = iq.enq_src1_tag_i;
      enq_ent.src1_rdy  = iq.enq_src1_rdy_i;
      enq_ent.src1_data = iq.enq_src1_data_i;
      enq_ent.src2_tag  = iq.enq_src2_tag_i;
      enq_ent.src2_rdy  = iq.enq_src2_rdy_i;
      enq_ent.src2_data = iq.enq_src2_data_i;
      enq_ent.fu        = iq.enq_fu_i;
      enq_ent.wait_sb   = iq.enq_wait_sb_i;
      enq_ent.sb_id     = iq.enq_sb_id_i;
      enq_ent.payload   = iq.enq_payload_i;
      for (int b = NUM_CDB_P - 1; b >= 0; b--) begin
         if (!iq.enq_src1_rdy_i && iq.cdb_v_i[b] &&
             iq.cdb_tag_i[b*TAG_W_P +: TAG_W_P] == iq.enq_src1_tag_i) begin
            enq_ent.src1_rdy  = 1'b1;
            enq_ent.src1_data = iq.cdb_data_i[b*DATA_W_P +: DATA_W_P];
         end
         if (!iq.enq_src2_rdy_i && iq.cdb_v_i[b] &&
             iq.cdb_tag_i[b*TAG_W_P +: TAG_W_P] == iq.enq_src2_tag_i) begin
            enq_ent.src2_rdy  = 1'b1;
            enq_ent.src2_data = iq.cdb_data_i[b*DATA_W_P +: DATA_W_P];
         end
      end
   end

   // Per-entry next state: wakeup, store-buffer clear, issue invalidate, enqueue, flush.
   always_comb begin
      for (int i = 0; i < ENTRIES_P; i++) begin
         ent_d[i]   = ent_q[i];
         valid_d[i] = valid_q[i] & ~sel[i];
         for (int b = NUM_CDB_P - 1; b >= 0; b--) begin
            if (!ent_q[i].src1_rdy && iq.cdb_v_i[b] &&
                iq.cdb_tag_i[b*TAG_W_P +: TAG_W_P] == ent_q[i].src1_tag) begin
               ent_d[i].src1_rdy  = 1'b1;
               ent_d[i].src1_data = iq.cdb_data_i[b*DATA_W_P +: DATA_W_P];
            end
            if (!ent_q[i].src2_rdy && iq.cdb_v_i[b] &&
                iq.cdb_tag_i[b*TAG_W_P +: TAG_W_P] == ent_q[i].src2_tag) begin
               ent_d[i].src2_rdy  = 1'b1;
               ent_d[i].src2_data = iq.cdb_data_i[b*DATA_W_P +: DATA_W_P];
            end
         end
         if (ent_q[i].wait_sb && iq.sb_clr_v_i && ent_q[i].sb_id == iq.sb_clr_id_i) begin
            ent_d[i].wait_sb = 1'b0;
         end
         if (enq_acc && free_oh[i]) begin
            ent_d[i]   = enq_ent;
            valid_d[i] = 1'b1;
         end
         if (iq.flush_i) begin
            valid_d[i] = 1'b0;
         end
      end
   end

   issue_age_select #(
      .ENTRIES_P (ENTRIES_P),
      .ISSUE_W_P (ISSUE_W_P),
      .NUM_FU_P  (NUM_FU_P)
   ) u_age_select (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .flush_i    (iq.flush_i),
      .enq_i      (enq_acc),
      .enq_oh_i   (free_oh),
      .ready_i    (ready),
      .entry_fu_i (ent_fu),
      .fu_ready_i (iq.fu_ready_i),
      .grant_o    (grant)
   );

   always_comb begin
      sel     = '0;
      sel_cnt = '0;
      for (int k = 0; k < ISSUE_W_P; k++) begin
         sel = sel | grant[k];
      end
      for (int i = 0; i < ENTRIES_P; i++) begin
         sel_cnt = sel_cnt + CNT_W'(sel[i]);
      end
      count_d     = iq.flush_i ? '0 : (count_q + CNT_W'(enq_acc) - sel_cnt);
      enq_ready_d = (count_d < FULL_CNT);
   end

   // Issue registers: one-hot grant mux; empty or flushed slots carry all zeros.
   always_comb begin
      iss_v_d    = '0;
      iss_fu_d   = '0;
      iss_src1_d = '0;
      iss_src2_d = '0;
      iss_pl_d   = '0;
      for (int k = 0; k < ISSUE_W_P; k++) begin
         for (int i = 0; i < ENTRIES_P; i++) begin
            if (grant[k][i] && !iq.flush_i) begin
               iss_v_d[k]    = 1'b1;
               iss_fu_d[k]   = ent_q[i].fu;
               iss_src1_d[k] = ent_q[i].src1_data;
               iss_src2_d[k] = ent_q[i].src2_data;
               iss_pl_d[k]   = ent_q[i].payload;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q     <= '0;
         count_q     <= '0;
         enq_ready_q <= 1'b0;
         iss_v_q     <= '0;
         iss_fu_q    <= '0;
         iss_src1_q  <= '0;
         iss_src2_q  <= '0;
         iss_pl_q    <= '0;
      end else begin
         valid_q     <= valid_d;
         count_q     <= count_d;
         enq_ready_q <= enq_ready_d;
         iss_v_q     <= iss_v_d;
         iss_fu_q    <= iss_fu_d;
         iss_src1_q  <= iss_src1_d;
         iss_src2_q  <= iss_src2_d;
         iss_pl_q    <= iss_pl_d;
      end
   end

   // Entry contents are qualified by valid_q, so they need no reset.
   always_ff @(posedge clk_i) begin
      ent_q <= ent_d;
   end

   assign iq.enq_ready_o   = enq_ready_q;
   assign iq.count_o       = count_q;
   assign iq.iss_v_o       = iss_v_q;
   assign iq.iss_fu_o      = iss_fu_q;
   assign iq.iss_src1_o    = iss_src1_q;
   assign iq.iss_src2_o    = iss_src2_q;
   assign iq.iss_payload_o = iss_pl_q;

endmodule
